not_share_arbiter: RTL and testbench

NOT_SHARE_ARBITER -- requirements
Module: not_share_arbiter

---
 rtl/not_share_pkg.sv | 12 +
 rtl/inv_lane.sv | 11 +
 rtl/not_share_arbiter.sv | 120 ++++++++++++
 tb/tb_not_share_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/not_share_pkg.sv
// Shared state encoding and default sizing for the not_share arbiter slice.
package not_share_pkg;

  localparam int unsigned DEF_N = 4;
  localparam int unsigned DEF_W = 8;
  localparam int unsigned ID_W  = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

endpackage

// File: rtl/inv_lane.sv
// Shared W-bit bitwise inverter lane.
module inv_lane #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] b
);

  assign b = ~a;

endmodule

// File: rtl/not_share_arbiter.sv
// Round-robin arbiter granting N requesters access to one shared inverter lane.
module not_share_arbiter
  import not_share_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned W = DEF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [N*W-1:0]    op_in,
  output logic [N-1:0]      ack,
  output logic [W-1:0]      res_out,
  output logic              res_valid,
  output logic [ID_W-1:0]   res_id,
  output logic              busy
);

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] win_q, win_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [W-1:0]    cap_q, cap_d;
  logic [N-1:0]    ack_d;
  logic            res_valid_d;
  logic [W-1:0]    res_out_d;
  logic [ID_W-1:0] res_id_d;
  logic            busy_d;
  logic [ID_W-1:0] pick;
  logic [W-1:0]    inv_b;

  // First set bit above last, then wrap to 0..last (last itself is lowest priority).
  function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0] r,
                                              input logic [ID_W-1:0] last);
    logic [ID_W-1:0] sel;
    logic            found;
    sel   = last;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && r[i] && (ID_W'(i) > last)) begin
        sel   = ID_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && r[i] && (ID_W'(i) <= last)) begin
        sel   = ID_W'(i);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign pick = rr_pick(req, last_q);

  inv_lane #(.W(W)) u_inv (
    .a (cap_q),
    .b (inv_b)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    last_d      = last_q;
    cap_d       = cap_q;
    ack_d       = '0;
    res_valid_d = 1'b0;
    res_out_d   = res_out;
    res_id_d    = res_id;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_CAPTURE;
          win_d   = pick;
          for (int i = 0; i < N; i++) begin
            ack_d[i] = (pick == ID_W'(i));
            if (pick == ID_W'(i)) cap_d = op_in[i*W +: W];
          end
        end
      end
      ST_CAPTURE: begin
        state_d     = ST_RESPOND;
        res_valid_d = 1'b1;
        res_out_d   = inv_b;
        res_id_d    = win_q;
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
        last_d  = win_q;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      win_q     <= '0;
      last_q    <= ID_W'(N - 1);
      cap_q     <= '0;
      ack       <= '0;
      res_valid <= 1'b0;
      res_out   <= '0;
      res_id    <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      last_q    <= last_d;
      cap_q     <= cap_d;
      ack       <= ack_d;
      res_valid <= res_valid_d;
      res_out   <= res_out_d;
      res_id    <= res_id_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_not_share_arbiter.sv
// Directed self-checking bench for not_share_arbiter (N=4, W=8).
module tb_not_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] op_in;
  logic [3:0]  ack;
  logic [7:0]  res_out;
  logic        res_valid;
  logic [2:0]  res_id;
  logic        busy;

  int errors = 0;
  int checks = 0;

  int unsigned g_tab[5] = '{0, 1, 2, 3, 0};
  logic [7:0]  r_tab[5] = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFF};

  not_share_arbiter #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_in     (op_in),
    .ack       (ack),
    .res_out   (res_out),
    .res_valid (res_valid),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst   = 1'b1;
    req   = 4'b0000;
    op_in = 32'h0;
    tick();
    tick();
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_rv", 32'(res_valid), 32'h0);
    chk("rst_rout", 32'(res_out), 32'h0);
    chk("rst_rid", 32'(res_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_noreq_busy", 32'(busy), 32'h0);

    // Single request, first latency.
    req   = 4'b0001;
    op_in = 32'h0000_000F;
    tick();
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_rv_cap", 32'(res_valid), 32'h0);
    req = 4'b0000;
    tick();
    chk("t1_rv", 32'(res_valid), 32'h1);
    chk("t1_rout", 32'(res_out), 32'hF0);
    chk("t1_rid", 32'(res_id), 32'h0);
    chk("t1_ack_resp", 32'(ack), 32'h0);
    tick();
    chk("t1_rv_idle", 32'(res_valid), 32'h0);
    chk("t1_busy_idle", 32'(busy), 32'h0);
    chk("t1_rout_hold", 32'(res_out), 32'hF0);

    // Sustained all-request load from reset.
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    req   = 4'b1111;
    op_in = 32'h0302_0100;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("t2_ack", 32'(ack), 32'h1 << g_tab[t]);
      tick();
      chk("t2_rv", 32'(res_valid), 32'h1);
      chk("t2_rid", 32'(res_id), g_tab[t]);
      chk("t2_rout", 32'(res_out), 32'(r_tab[t]));
      tick();
      chk("t2_busy_idle", 32'(busy), 32'h0);
    end
    req = 4'b0000;

    // Make last_grant=3, then simultaneous req 0 and 3.
    req = 4'b1000;
    tick();
    chk("t3_pre_ack", 32'(ack), 32'h8);
    req = 4'b0000;
    tick();
    chk("t3_pre_rid", 32'(res_id), 32'h3);
    chk("t3_pre_rout", 32'(res_out), 32'hFC);
    tick();
    req = 4'b1001;
    tick();
    chk("t3_ack0", 32'(ack), 32'h1);
    req = 4'b1000;
    tick();
    chk("t3_rid0", 32'(res_id), 32'h0);
    chk("t3_rout0", 32'(res_out), 32'hFF);
    tick();
    tick();
    chk("t3_ack3", 32'(ack), 32'h8);
    req = 4'b0000;
    tick();
    chk("t3_rid3", 32'(res_id), 32'h3);
    tick();

    // Reset aborts a transaction before its result; held request re-served.
    op_in[23:16] = 8'h5A;
    req = 4'b0100;
    tick();
    chk("t4_ack", 32'(ack), 32'h4);
    rst = 1'b1;
    tick();
    chk("t4_abort_rv", 32'(res_valid), 32'h0);
    chk("t4_abort_rout", 32'(res_out), 32'h0);
    chk("t4_abort_rid", 32'(res_id), 32'h0);
    chk("t4_abort_busy", 32'(busy), 32'h0);
    chk("t4_abort_ack", 32'(ack), 32'h0);
    rst = 1'b0;
    tick();
    chk("t4_reack", 32'(ack), 32'h4);
    req = 4'b0000;
    tick();
    chk("t4_rv", 32'(res_valid), 32'h1);
    chk("t4_rout", 32'(res_out), 32'hA5);
    chk("t4_rid", 32'(res_id), 32'h2);
    tick();

    // Request arriving during CAPTURE waits; ack spacing is 3 cycles.
    req = 4'b0010;
    tick();
    chk("t5_ack1", 32'(ack), 32'h2);
    req = 4'b0100;
    tick();
    chk("t5_resp_ack", 32'(ack), 32'h0);
    chk("t5_rid1", 32'(res_id), 32'h1);
    chk("t5_rout1", 32'(res_out), 32'hFE);
    tick();
    chk("t5_idle_ack", 32'(ack), 32'h0);
    tick();
    chk("t5_ack2", 32'(ack), 32'h4);
    req = 4'b0000;
    tick();
    chk("t5_rid2", 32'(res_id), 32'h2);
    chk("t5_rout2", 32'(res_out), 32'hA5);
    tick();

    // Requester 1 drops before grant; only requester 3 served.
    rst = 1'b1;
    req = 4'b1010;
    tick();
    chk("t6_rst_ack", 32'(ack), 32'h0);
    rst = 1'b0;
    req = 4'b1000;
    tick();
    chk("t6_ack", 32'(ack), 32'h8);
    req = 4'b0000;
    tick();
    chk("t6_rv", 32'(res_valid), 32'h1);
    chk("t6_rid", 32'(res_id), 32'h3);
    chk("t6_rout", 32'(res_out), 32'hFC);
    tick();
    tick();
    chk("t6_no_more_ack", 32'(ack), 32'h0);
    chk("t6_idle_busy", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
